// File: rtl/plab1_imul_int_div_rem_var_lat.sv
// plab1_imul_int_div_rem_var_lat: iterative restoring divide/remainder unit.
// Only the significant bits of |a| are iterated, so latency tracks the dividend width.
module plab1_imul_int_div_rem_var_lat #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [1:0]         in_func,
  input  logic [p_nbits-1:0] in_a,
  input  logic [p_nbits-1:0] in_b,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg
);
  localparam int W  = p_nbits;
  localparam int CW = $clog2(W) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t         state_q, state_d;
  logic [1:0]     func_q, func_d;
  logic           sa_q, sa_d, sb_q, sb_d;
  logic [W-1:0]   dvd_q, dvd_d, b_q, b_d, msg_q, msg_d;
  logic [W:0]     rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sgn, ge;
  logic [W-1:0]   a_abs, b_abs, d_nx, q_s, r_s;
  logic [W:0]     r_sh, r_nx;
  logic [CW-1:0]  clz, n;
  always_comb begin
    sgn   = ~in_func[0];
    a_abs = (sgn & in_a[W-1]) ? -in_a : in_a;
    b_abs = (sgn & in_b[W-1]) ? -in_b : in_b;
    clz   = CW'(W);
    for (int i = 0; i < W; i++) clz = a_abs[i] ? CW'(W - 1 - i) : clz;
    n     = CW'(W) - clz;
    // Dividend shifts out its MSB while quotient bits fill in from the LSB.
    r_sh  = {rem_q[W-1:0], dvd_q[W-1]};
    ge    = rem_q[W] | (r_sh >= {1'b0, b_q});
    r_nx  = ge ? r_sh - {1'b0, b_q} : r_sh;
    d_nx  = {dvd_q[W-2:0], ge};
    q_s   = (sa_q ^ sb_q) ? -d_nx : d_nx;
    r_s   = sa_q ? -r_nx[W-1:0] : r_nx[W-1:0];
    state_d = state_q;
    func_d  = func_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dvd_d   = dvd_q;
    b_d     = b_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    msg_d   = msg_q;
    if (state_q == IDLE) begin
      if (in_val) begin
        func_d  = in_func;
        sa_d    = sgn & in_a[W-1];
        sb_d    = sgn & in_b[W-1];
        dvd_d   = a_abs << clz;
        b_d     = b_abs;
        rem_d   = '0;
        cnt_d   = n;
        state_d = (b_abs == '0 || n == '0) ? DONE : CALC;
        msg_d   = (b_abs == '0) ? (in_func[1] ? in_a : '1) : '0;
      end
    end else if (state_q == CALC) begin
      rem_d = r_nx;
      dvd_d = d_nx;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = DONE;
        msg_d   = func_q[1] ? r_s : q_s;
      end
    end else begin
      state_d = out_rdy ? IDLE : DONE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      func_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dvd_q   <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dvd_q   <= dvd_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      msg_q   <= msg_d;
    end
  end
  assign in_rdy  = (state_q == IDLE);
  assign out_val = (state_q == DONE);
  assign out_msg = msg_q;
endmodule

// File: tb/tb_plab1_imul_int_div_rem_var_lat.sv
// tb_plab1_imul_int_div_rem_var_lat: directed and randomized checks of the divide/remainder unit.
module tb_plab1_imul_int_div_rem_var_lat;
  logic        clk = 1'b0, reset = 1'b1, in_val = 1'b0, out_rdy = 1'b0;
  logic [1:0]  in_func = 2'd0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_rdy, out_val;
  logic [31:0] out_msg;
  int          n_assert = 0, n_fail = 0;

  plab1_imul_int_div_rem_var_lat #(.p_nbits(32)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_func(in_func),
    .in_a(in_a), .in_b(in_b), .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat_exp, input int stall);
    int lat;
    chk({tag, " in_rdy_pre"}, {31'd0, in_rdy}, 32'd1);
    in_val = 1'b1; in_func = f; in_a = a; in_b = b;
    tick;
    in_val = 1'b0; in_func = 2'($urandom); in_a = $urandom; in_b = $urandom;
    lat = 1;
    while (!out_val && lat < 40) begin
      tick;
      lat++;
    end
    chk({tag, " latency"}, lat, lat_exp);
    chk({tag, " msg"}, out_msg, exp);
    for (int i = 0; i < stall; i++) begin
      tick;
      chk({tag, " hold_val"}, {31'd0, out_val}, 32'd1);
      chk({tag, " hold_msg"}, out_msg, exp);
      chk({tag, " hold_rdy"}, {31'd0, in_rdy}, 32'd0);
    end
    out_rdy = 1'b1;
    tick;
    out_rdy = 1'b0;
    chk({tag, " val_clr"}, {31'd0, out_val}, 32'd0);
    chk({tag, " in_rdy_post"}, {31'd0, in_rdy}, 32'd1);
  endtask

  function automatic logic [31:0] gold(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return f[1] ? a : 32'hFFFFFFFF;
    if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return f[1] ? 32'd0 : a;
    case (f)
      2'd0:    return sa / sb;
      2'd1:    return a / b;
      2'd2:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int glat(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m;
    int nb;
    if (b == 32'd0) return 1;
    m  = (!f[0] && a[31]) ? -a : a;
    nb = 0;
    for (int i = 0; i < 32; i++) if (m[i]) nb = i + 1;
    return 1 + nb;
  endfunction

  initial begin
    logic [1:0]  f;
    logic [31:0] a, b;
    int          sel;
    tick;
    tick;
    reset = 1'b0;
    chk("rst out_val", {31'd0, out_val}, 32'd0);
    chk("rst in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("rst out_msg", out_msg, 32'd0);

    do_op("divu100_7", 2'd1, 32'd100, 32'd7, 32'd14, 8, 0);
    do_op("remu100_7", 2'd3, 32'd100, 32'd7, 32'd2, 8, 0);
    do_op("div-7_2", 2'd0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 4, 0);
    do_op("rem-7_2", 2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 4, 0);
    do_op("div7_-2", 2'd0, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 4, 0);
    do_op("rem7_-2", 2'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 4, 0);
    do_op("div_ovf", 2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 0);
    do_op("rem_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33, 0);
    do_op("divu_max_1", 2'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33, 0);
    do_op("divu5_0", 2'd1, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
    do_op("rem-5_0", 2'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1, 0);
    do_op("div0_9", 2'd0, 32'd0, 32'd9, 32'd0, 1, 0);
    do_op("remu0_9", 2'd3, 32'd0, 32'd9, 32'd0, 1, 0);
    do_op("backpressure", 2'd1, 32'd100, 32'd7, 32'd14, 8, 10);
    do_op("back2back", 2'd3, 32'd50, 32'd8, 32'd2, 7, 0);

    in_val = 1'b1; in_func = 2'd1; in_a = 32'hFFFFFFFF; in_b = 32'd3;
    tick;
    in_val = 1'b0;
    for (int i = 0; i < 9; i++) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("midrst out_val", {31'd0, out_val}, 32'd0);
    chk("midrst in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("midrst out_msg", out_msg, 32'd0);
    do_op("after_rst_9_3", 2'd1, 32'd9, 32'd3, 32'd3, 5, 0);

    for (int k = 0; k < 1000; k++) begin
      f   = 2'($urandom_range(0, 3));
      a   = $urandom >> $urandom_range(0, 31);
      b   = $urandom >> $urandom_range(0, 31);
      sel = $urandom_range(0, 15);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if (sel == 2) a = 32'd0;
      if (sel == 3) b = -b;
      if (sel == 4) a = -a;
      do_op("rand", f, a, b, gold(f, a, b), glat(f, a, b), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
